// File: rtl/branch_predictor_pkg.sv
// Processor-wide constants shared by the fetch-side predictor: PC geometry and
// the 2-bit saturating counter encoding with its step function.
package branch_predictor_pkg;

    localparam int unsigned PC_W       = 64;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // One saturating step toward taken (up=1) or not-taken (up=0)
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && (c != ST)) begin
            r = 2'(c + 2'd1);
        end else if (!up && (c != SNT)) begin
            r = 2'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter; resets asynchronously to weak-not-taken,
// load forces weak-taken on BTB allocation.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_i,
    input  logic       taken_i,
    input  logic       load_i,
    output logic [1:0] ctr_o
);

    logic [1:0] ctr_q;
    logic [1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_i) begin
            ctr_d = WT;
        end else if (upd_i) begin
            ctr_d = ctr_step(ctr_q, taken_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_q <= WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: zero-latency lookup for
// fetch, one registered training update per cycle from the memory stage.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              predict_taken,
    output logic [PC_W-1:0]   predict_target,
    input  logic              update_valid,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              update_taken,
    input  logic              update_uncond,
    input  logic [PC_W-1:0]   update_target,
    input  logic              update_mispredict,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = PC_W - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] uncond_q, uncond_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr      [ENTRIES];
    logic [ENTRIES-1:0] ctr_upd, ctr_load;
    logic [CNT_W-1:0]   branch_q, branch_d, mis_q, mis_d;

    logic [INDEX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               f_hit, f_taken, u_hit;
    logic               unused_low_bits;

    assign f_idx = fetch_pc[INDEX_W+1:2];
    assign f_tag = fetch_pc[PC_W-1:INDEX_W+2];
    assign u_idx = update_pc[INDEX_W+1:2];
    assign u_tag = update_pc[PC_W-1:INDEX_W+2];
    assign unused_low_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    // Lookup sees pre-update state; no bypass from the update port
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit && (uncond_q[f_idx] || ctr[f_idx][1]);
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign predict_taken  = !reset && f_taken;
    assign predict_target = reset   ? '0 :
                            f_taken ? target_q[f_idx] :
                                      fetch_pc + PC_W'(INSN_BYTES);

    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_upd  = '0;
        ctr_load = '0;
        branch_d = branch_q;
        mis_d    = mis_q;
        if (update_valid) begin
            branch_d = branch_q + CNT_W'(1);
            if (update_mispredict) begin
                mis_d = mis_q + CNT_W'(1);
            end
            if (u_hit) begin
                ctr_upd[u_idx] = 1'b1;
                if (update_taken) begin
                    target_d[u_idx] = update_target;
                    uncond_d[u_idx] = update_uncond;
                end
            end else if (update_taken) begin
                // Allocate or replace the aliasing entry; not-taken misses never allocate
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = update_target;
                uncond_d[u_idx] = update_uncond;
                ctr_load[u_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            uncond_q <= '0;
            branch_q <= '0;
            mis_q    <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            uncond_q <= uncond_d;
            branch_q <= branch_d;
            mis_q    <= mis_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_ctr
        sat_counter2 u_ctr (
            .clk     (clk),
            .reset   (reset),
            .upd_i   (ctr_upd[g]),
            .taken_i (update_taken),
            .load_i  (ctr_load[g]),
            .ctr_o   (ctr[g])
        );
    end

    assign branch_count     = branch_q;
    assign mispredict_count = mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a training/lookup vector table plus
// hand sequences for same-cycle lookup, counters, wrap and async reset.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] fetch_pc;
    logic        predict_taken;
    logic [63:0] predict_target;
    logic        update_valid, update_taken, update_uncond, update_mispredict;
    logic [63:0] update_pc, update_target;
    logic [31:0] branch_count, mispredict_count;
    logic        unused_pt2;
    logic [63:0] unused_ptgt2;
    logic [3:0]  branch_count2, mispredict_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_uncond(update_uncond),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    // Narrow-counter instance on the same traffic, to exercise wrap-around
    branch_predictor #(.ENTRIES(16), .CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .predict_taken(unused_pt2), .predict_target(unused_ptgt2),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_uncond(update_uncond),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .branch_count(branch_count2), .mispredict_count(mispredict_count2)
    );

    typedef struct {
        logic        uv;
        logic [63:0] upc;
        logic        tk;
        logic        unc;
        logic [63:0] tgt;
        logic        mis;
        logic [63:0] fpc;
        logic        exp_tk;
        logic [63:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        update_valid = 0; update_taken = 0; update_uncond = 0;
        update_mispredict = 0; update_pc = '0; update_target = '0;
    endtask

    // One update cycle through the edge, then inputs go idle
    task automatic do_update(input logic [63:0] pc, input logic tk, input logic mis);
        update_valid = 1; update_pc = pc; update_taken = tk;
        update_uncond = 0; update_target = 64'h700; update_mispredict = mis;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] exp_br, exp_mis;
        reset = 1; fetch_pc = 64'h100;
        idle_inputs();

        // uv, upc, tk, unc, tgt, mis, fpc, exp_tk, exp_tgt
        vecs.push_back('{0, 64'h000, 0, 0, 64'h00, 0, 64'h100, 0, 64'h104});
        vecs.push_back('{1, 64'h100, 1, 0, 64'h40, 1, 64'h100, 1, 64'h040});
        vecs.push_back('{1, 64'h100, 0, 0, 64'h00, 0, 64'h100, 0, 64'h104});
        vecs.push_back('{1, 64'h100, 0, 0, 64'h00, 0, 64'h100, 0, 64'h104});
        vecs.push_back('{1, 64'h100, 0, 0, 64'h00, 0, 64'h100, 0, 64'h104});
        vecs.push_back('{1, 64'h100, 1, 0, 64'h40, 0, 64'h100, 0, 64'h104});
        vecs.push_back('{1, 64'h100, 1, 0, 64'h40, 0, 64'h100, 1, 64'h040});
        vecs.push_back('{1, 64'h140, 1, 0, 64'h80, 1, 64'h100, 0, 64'h104});
        vecs.push_back('{0, 64'h000, 0, 0, 64'h00, 1, 64'h140, 1, 64'h080});
        vecs.push_back('{1, 64'h200, 1, 1, 64'h10, 0, 64'h200, 1, 64'h010});
        vecs.push_back('{1, 64'h200, 0, 0, 64'h00, 1, 64'h200, 1, 64'h010});
        vecs.push_back('{1, 64'h500, 0, 0, 64'h99, 0, 64'h500, 0, 64'h504});
        vecs.push_back('{0, 64'h000, 0, 0, 64'h00, 0, 64'h202, 1, 64'h010});
        vecs.push_back('{1, 64'h404, 1, 0, 64'h20, 0, 64'h404, 1, 64'h020});
        vecs.push_back('{1, 64'h404, 1, 0, 64'h20, 0, 64'h404, 1, 64'h020});
        vecs.push_back('{1, 64'h404, 1, 0, 64'h20, 0, 64'h404, 1, 64'h020});
        vecs.push_back('{1, 64'h404, 0, 0, 64'h00, 0, 64'h404, 1, 64'h020});
        vecs.push_back('{1, 64'h404, 0, 0, 64'h00, 0, 64'h404, 0, 64'h408});

        // Outputs forced to zero while reset is held
        #2;
        chk("reset_pt", 64'(predict_taken), 64'd0);
        chk("reset_ptgt", predict_target, 64'd0);
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("post_reset_pt", 64'(predict_taken), 64'd0);
        chk("post_reset_ptgt", predict_target, 64'h104);
        chk("post_reset_br", 64'(branch_count), 64'd0);
        chk("post_reset_mis", 64'(mispredict_count), 64'd0);

        exp_br = 0; exp_mis = 0;
        foreach (vecs[i]) begin
            update_valid = vecs[i].uv; update_pc = vecs[i].upc;
            update_taken = vecs[i].tk; update_uncond = vecs[i].unc;
            update_target = vecs[i].tgt; update_mispredict = vecs[i].mis;
            fetch_pc = vecs[i].fpc;
            exp_br  += 32'(vecs[i].uv);
            exp_mis += 32'(vecs[i].uv & vecs[i].mis);
            @(posedge clk); #1;
            idle_inputs();
            #1;
            chk($sformatf("vec%0d_pt", i), 64'(predict_taken), 64'(vecs[i].exp_tk));
            chk($sformatf("vec%0d_ptgt", i), predict_target, vecs[i].exp_tgt);
        end
        chk("table_br", 64'(branch_count), 64'(exp_br));
        chk("table_mis", 64'(mispredict_count), 64'(exp_mis));

        // Same-cycle lookup of a first-ever update sees the old (empty) entry
        update_valid = 1; update_pc = 64'h300; update_taken = 1;
        update_target = 64'h50; fetch_pc = 64'h300;
        #1;
        chk("samecyc_pt", 64'(predict_taken), 64'd0);
        chk("samecyc_ptgt", predict_target, 64'h304);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("nextcyc_pt", 64'(predict_taken), 64'd1);
        chk("nextcyc_ptgt", predict_target, 64'h50);

        // Asynchronous reset clears counts without a clock edge
        reset = 1;
        #2;
        chk("async_rst_br", 64'(branch_count), 64'd0);
        chk("async_rst_mis", 64'(mispredict_count), 64'd0);
        chk("async_rst_pt", 64'(predict_taken), 64'd0);
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("async_rst_entry", 64'(predict_taken), 64'd0);

        // Counts: three updates, two mispredicts, plus an unqualified mispredict
        do_update(64'h800, 1, 1);
        do_update(64'h804, 0, 1);
        update_mispredict = 1;
        @(posedge clk); #1;
        idle_inputs();
        do_update(64'h808, 1, 0);
        chk("cnt_br", 64'(branch_count), 64'd3);
        chk("cnt_mis", 64'(mispredict_count), 64'd2);

        // Narrow counters wrap from all-ones to zero
        for (int k = 0; k < 12; k++) do_update(64'h900, 0, 1);
        chk("w4_br_full", 64'(branch_count2), 64'hF);
        chk("w4_mis", 64'(mispredict_count2), 64'd14);
        do_update(64'h900, 0, 1);
        chk("w4_br_wrap", 64'(branch_count2), 64'd0);
        chk("w4_mis_full", 64'(mispredict_count2), 64'hF);
        do_update(64'h900, 0, 1);
        chk("w4_mis_wrap", 64'(mispredict_count2), 64'd0);
        chk("wide_br", 64'(branch_count), 64'd17);

        // Reset wins over an update presented at the same edge
        update_valid = 1; update_pc = 64'h600; update_taken = 1;
        update_target = 64'h60; update_mispredict = 1; fetch_pc = 64'h600;
        reset = 1;
        @(posedge clk); #1;
        idle_inputs();
        reset = 0;
        #1;
        chk("rst_win_pt", 64'(predict_taken), 64'd0);
        chk("rst_win_ptgt", predict_target, 64'h604);
        chk("rst_win_br", 64'(branch_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
